convol_frame_ctrl: RTL

- Sequencer for the one-dimensional convolution kernel.
- Holds the kernel coefficient bank, written through a simple config port.
- Accepts a frame of samples over a valid/ready stream and drives the kernel's input_data/enable one sample per cycle.
- Appends NUM_TAPS-1 zero samples to flush the filter tail, counts kernel output_data_valid pulses, and signals frame completion.

---
 rtl/convol_frame_ctrl_pkg.sv | 24 ++
 rtl/convol_frame_ctrl_if.sv | 46 ++++
 rtl/convol_frame_ctrl_coeff_bank.sv | 45 ++++
 rtl/convol_frame_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/convol_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// convol_frame_ctrl_pkg
// Shared constants and types for the convolution frame controller:
//   CONVOL_* default widths/tap count, coeff_t coefficient bank type,
//   ctrl_state_t frame sequencer states.
// -----------------------------------------------------------------------------
package convol_frame_ctrl_pkg;

    localparam int CONVOL_NUM_TAPS    = 8;
    localparam int CONVOL_COEFF_WIDTH = 16;
    localparam int CONVOL_DATA_WIDTH  = 16;
    localparam int CONVOL_LEN_WIDTH   = 16;

    typedef logic [CONVOL_COEFF_WIDTH-1:0] coeff_t [CONVOL_NUM_TAPS];

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/convol_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// convol_frame_ctrl_if
// Bundles the controller's config port, sample stream, kernel drive/return
// and status signals.
//   master : the environment side (drives cfg/start/stream/kernel valid)
//   slave  : the controller side (drives s_ready, kernel outputs, status)
// -----------------------------------------------------------------------------
interface convol_frame_ctrl_if
    import convol_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = CONVOL_DATA_WIDTH,
    parameter int COEFF_WIDTH = CONVOL_COEFF_WIDTH,
    parameter int NUM_TAPS    = CONVOL_NUM_TAPS,
    parameter int LEN_WIDTH   = CONVOL_LEN_WIDTH
);
    logic                         cfg_wr;
    logic [$clog2(NUM_TAPS)-1:0]  cfg_addr;
    logic [COEFF_WIDTH-1:0]       cfg_data;
    logic                         start;
    logic [LEN_WIDTH-1:0]         frame_len;
    logic [DATA_WIDTH-1:0]        s_data;
    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_WIDTH-1:0]        kernel_input_data;
    logic                         kernel_enable;
    logic [COEFF_WIDTH-1:0]       kernel_coeff [NUM_TAPS];
    logic                         kernel_output_valid;
    logic                         busy;
    logic                         frame_done;
    logic [LEN_WIDTH-1:0]         out_count;

    modport master (
        output cfg_wr, cfg_addr, cfg_data, start, frame_len, s_data, s_valid,
               kernel_output_valid,
        input  s_ready, kernel_input_data, kernel_enable, kernel_coeff,
               busy, frame_done, out_count
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, start, frame_len, s_data, s_valid,
               kernel_output_valid,
        output s_ready, kernel_input_data, kernel_enable, kernel_coeff,
               busy, frame_done, out_count
    );

endinterface

// File: rtl/convol_frame_ctrl_coeff_bank.sv
// -----------------------------------------------------------------------------
// convol_frame_ctrl_coeff_bank
// Coefficient register file for the convolution kernel.
//   clk, reset : clock, asynchronous active-high reset (clears all taps)
//   i_idle     : controller is idle; writes are accepted only then
//   i_wr       : write strobe
//   i_addr     : tap index (indices >= NUM_TAPS are dropped)
//   i_data     : coefficient value
//   o_coeff    : current coefficient bank, updated the cycle after a write
// -----------------------------------------------------------------------------
module convol_frame_ctrl_coeff_bank
    import convol_frame_ctrl_pkg::*;
#(
    parameter int COEFF_WIDTH = CONVOL_COEFF_WIDTH,
    parameter int NUM_TAPS    = CONVOL_NUM_TAPS,
    parameter int ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_idle,
    input  logic                   i_wr,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [COEFF_WIDTH-1:0] i_data,
    output logic [COEFF_WIDTH-1:0] o_coeff [NUM_TAPS]
);

    logic [COEFF_WIDTH-1:0] r_coeff [NUM_TAPS];
    logic                   w_wr_en;

    // Gating to idle keeps the bank frozen for the whole frame.
    assign w_wr_en = i_idle && i_wr && (32'(i_addr) < 32'(NUM_TAPS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coeff[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_coeff[i_addr] <= i_data;
        end
    end

    assign o_coeff = r_coeff;

endmodule

// File: rtl/convol_frame_ctrl.sv
// -----------------------------------------------------------------------------
// convol_frame_ctrl
// Frame sequencer for the 1-D convolution kernel. Accepts a frame of samples
// on a valid/ready stream, drives the kernel one sample per cycle, appends
// NUM_TAPS-1 zero samples to flush the tail, counts kernel output valids and
// pulses frame_done once the expected number of outputs has been seen.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : config port, sample stream, kernel drive/return, status
// All outputs are registered.
// -----------------------------------------------------------------------------
module convol_frame_ctrl
    import convol_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = CONVOL_DATA_WIDTH,
    parameter int COEFF_WIDTH = CONVOL_COEFF_WIDTH,
    parameter int NUM_TAPS    = CONVOL_NUM_TAPS,
    parameter int LEN_WIDTH   = CONVOL_LEN_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    convol_frame_ctrl_if.slave  bus
);

    localparam int FW = $clog2(NUM_TAPS);

    ctrl_state_t             r_state;
    ctrl_state_t             w_next_state;

    logic [LEN_WIDTH-1:0]    r_frame_len;
    logic [LEN_WIDTH:0]      r_exp_cnt;
    logic [LEN_WIDTH-1:0]    r_in_cnt;
    logic [FW-1:0]           r_flush_cnt;
    logic [LEN_WIDTH-1:0]    r_out_count;
    logic                    r_s_ready;
    logic [DATA_WIDTH-1:0]   r_kernel_data;
    logic                    r_kernel_enable;
    logic                    r_busy;
    logic                    r_frame_done;
    logic [COEFF_WIDTH-1:0]  w_coeff [NUM_TAPS];

    logic w_start_ok;
    logic w_accept;
    logic w_last_accept;
    logic w_flush_last;
    logic w_drained;

    convol_frame_ctrl_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS)
    ) u_coeff_bank (
        .clk     (clk),
        .reset   (reset),
        .i_idle  (r_state == IDLE),
        .i_wr    (bus.cfg_wr),
        .i_addr  (bus.cfg_addr),
        .i_data  (bus.cfg_data),
        .o_coeff (w_coeff)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_ok    = (r_state == IDLE) && bus.start;
        w_accept      = (r_state == RUN) && bus.s_valid && r_s_ready;
        w_last_accept = w_accept && ((r_in_cnt + LEN_WIDTH'(1)) == r_frame_len);
        w_flush_last  = (r_flush_cnt == FW'(NUM_TAPS - 2));
        w_drained     = ({1'b0, r_out_count} == r_exp_cnt);
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.frame_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_accept) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drained) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_len     <= '0;
            r_exp_cnt       <= '0;
            r_in_cnt        <= '0;
            r_flush_cnt     <= '0;
            r_out_count     <= '0;
            r_s_ready       <= 1'b0;
            r_kernel_data   <= '0;
            r_kernel_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            // Ready/busy follow the next state so they line up with r_state.
            r_s_ready       <= (w_next_state == RUN);
            r_busy          <= (w_next_state != IDLE);
            r_frame_done    <= (r_state == DONE);
            // Stream gaps in RUN show up as enable gaps at the kernel.
            r_kernel_enable <= w_accept || (r_state == FLUSH);

            if (w_accept) begin
                r_kernel_data <= bus.s_data;
            end else if (r_state == FLUSH) begin
                r_kernel_data <= '0;
            end

            if (w_start_ok) begin
                r_frame_len <= bus.frame_len;
                r_exp_cnt   <= {1'b0, bus.frame_len} + (LEN_WIDTH+1)'(NUM_TAPS - 1);
                r_in_cnt    <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
                end
                if (r_state == FLUSH) begin
                    r_flush_cnt <= r_flush_cnt + FW'(1);
                end
            end

            // Kernel latency overlaps RUN/FLUSH, so count in every busy state.
            if (w_start_ok) begin
                r_out_count <= '0;
            end else if ((r_state != IDLE) && bus.kernel_output_valid &&
                         (r_out_count != '1)) begin
                r_out_count <= r_out_count + LEN_WIDTH'(1);
            end
        end
    end

    assign bus.s_ready           = r_s_ready;
    assign bus.kernel_input_data = r_kernel_data;
    assign bus.kernel_enable     = r_kernel_enable;
    assign bus.kernel_coeff      = w_coeff;
    assign bus.busy              = r_busy;
    assign bus.frame_done        = r_frame_done;
    assign bus.out_count         = r_out_count;

endmodule
